polirv_mem: RTL and testbench

Memory responder for the `polirv` core: the far end of both the instruction-fetch and the data-memory ports. It serves combinational instruction fetches and 64-bit data loads, and accepts data stores on the clock edge. It owns the shared `d_mem_data` bus. It also runs the boot sequence: clear data memory, load a program byte stream into instruction memory, then release the core from reset.

---
 rtl/polirv_pkg.sv | 14 +
 rtl/polirv_boot_loader.sv | 96 +++++++++
 rtl/polirv_mem.sv | 74 +++++++
 tb/tb_polirv_mem.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polirv_pkg.sv
// Shared definitions for the polirv memory responder and its boot loader.
package polirv_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } mem_state_t;

  localparam logic [31:0] NOP_INSN            = 32'h0000_0013;
  localparam int          IMEM_BYTES_PER_WORD = 4;
  localparam int          DMEM_WORD_BYTES     = 8;

endpackage

// File: rtl/polirv_boot_loader.sv
// Boot sequencer: clears data memory, assembles the program byte stream into
// instruction words, then releases the core. Loader handshake: a byte moves on
// every rising edge where ld_valid && ld_ready; ld_ready is high only in LOAD.
module polirv_boot_loader
  import polirv_pkg::*;
#(
  parameter int i_addr_bits = 6,
  parameter int d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_ovf,
  output logic                   cpu_rst_n,
  output logic                   clr_we,
  output logic [d_addr_bits-1:0] clr_addr,
  output logic                   imem_we,
  output logic [i_addr_bits-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output mem_state_t             state
);

  mem_state_t             next_state;
  logic [d_addr_bits-1:0] clr_cnt;
  logic [1:0]             byte_cnt;
  // Extra top bit marks "past the last word"; once set the counter saturates.
  logic [i_addr_bits:0]   word_cnt;
  logic [31:0]            asm_word;
  logic                   accept;
  logic                   word_done;
  logic                   full;

  assign full       = word_cnt[i_addr_bits];
  assign word_done  = (byte_cnt == 2'(IMEM_BYTES_PER_WORD - 1)) || ld_last;
  // asm_word is zeroed at each word start, so upper lanes read as zero fill.
  assign imem_wdata = asm_word | (32'(ld_data) << {byte_cnt, 3'b000});
  assign imem_addr  = word_cnt[i_addr_bits-1:0];
  assign clr_addr   = clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ld_ready   = 1'b0;
    clr_we     = 1'b0;
    imem_we    = 1'b0;
    accept     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == '1) next_state = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        accept   = ld_valid;
        imem_we  = ld_valid && !full && word_done;
        if (ld_valid && ld_last) next_state = RUN;
      end
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt   <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      asm_word  <= '0;
      ld_ovf    <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      cpu_rst_n <= (state == RUN);
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        if (full) begin
          ld_ovf <= 1'b1;
        end else if (word_done) begin
          word_cnt <= word_cnt + 1'b1;
          byte_cnt <= '0;
          asm_word <= '0;
        end else begin
          asm_word <= imem_wdata;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/polirv_mem.sv
// Memory responder for the polirv core: instruction and data arrays, the
// shared data bus driver, and the boot loader that fills them.
module polirv_mem
  import polirv_pkg::*;
#(
  parameter int i_addr_bits = 6,
  parameter int d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [i_addr_bits-1:0] i_mem_addr,
  output logic [31:0]            i_mem_data,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [7:0]             ld_data,
  input  logic                   ld_last,
  output logic                   cpu_rst_n,
  output logic                   ld_ovf
);

  localparam int IDEPTH = 1 << i_addr_bits;
  localparam int DDEPTH = 1 << d_addr_bits;
  localparam int DW     = DMEM_WORD_BYTES * 8;

  logic [31:0] imem [IDEPTH];
  logic [DW-1:0] dmem [DDEPTH];

  mem_state_t             state;
  logic                   run;
  logic                   clr_we;
  logic [d_addr_bits-1:0] clr_addr;
  logic                   imem_we;
  logic [i_addr_bits-1:0] imem_addr;
  logic [31:0]            imem_wdata;

  polirv_boot_loader #(
    .i_addr_bits(i_addr_bits),
    .d_addr_bits(d_addr_bits)
  ) u_boot (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_ovf    (ld_ovf),
    .cpu_rst_n (cpu_rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .state     (state)
  );

  assign run = (state == RUN);

  // Instruction memory is deliberately not reset: unloaded words persist.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (clr_we)             dmem[clr_addr]   <= '0;
    else if (run && d_mem_we) dmem[d_mem_addr] <= d_mem_data;
  end

  assign i_mem_data = run ? imem[i_mem_addr] : NOP_INSN;
  assign d_mem_data = (run && !d_mem_we) ? dmem[d_mem_addr] : 'z;

endmodule

// File: tb/tb_polirv_mem.sv
// Directed bench for polirv_mem: boot clear/load timing, program assembly,
// overflow handling, run-time data bus and reset behaviour.
module tb_polirv_mem;

  localparam int IAB = 6;
  localparam int DAB = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [IAB-1:0] i_mem_addr = '0;
  logic [31:0]    i_mem_data;
  logic           d_mem_we = 1'b0;
  logic [DAB-1:0] d_mem_addr = '0;
  wire  [63:0]    d_mem_data;
  logic           ld_valid = 1'b0;
  logic           ld_ready;
  logic [7:0]     ld_data = '0;
  logic           ld_last = 1'b0;
  logic           cpu_rst_n;
  logic           ld_ovf;

  logic [63:0]    tb_drv = '0;
  logic           tb_drv_en = 1'b0;
  assign d_mem_data = tb_drv_en ? tb_drv : 'z;

  int checks = 0;
  int errors = 0;

  polirv_mem #(.i_addr_bits(IAB), .d_addr_bits(DAB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data),
    .d_mem_we  (d_mem_we),
    .d_mem_addr(d_mem_addr),
    .d_mem_data(d_mem_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .cpu_rst_n (cpu_rst_n),
    .ld_ovf    (ld_ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic release_and_time_clear();
    int cycles;
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cycles++;
      if (ld_ready) break;
    end
    checks++;
    if (cycles !== 64) begin
      errors++;
      $display("FAIL clear_len: ld_ready rose after %0d cycles, expected 64", cycles);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    for (int i = 0; i < 10 && !ld_ready; i++) @(negedge clk);
    if (!ld_ready) begin
      errors++;
      $display("FAIL ld_ready_timeout: got %0b, expected 1", ld_ready);
    end
    @(posedge clk);
  endtask

  task automatic stop_stream();
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_mem_addr = 6'd3;
    tb_drv_en  = 1'b1;
    tb_drv     = '0;
    #1;
    checks++;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_rst_n: got %0b expected 0", cpu_rst_n); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready: got %0b expected 0", ld_ready); end
    checks++;
    if (ld_ovf !== 1'b0) begin errors++; $display("FAIL rst_ld_ovf: got %0b expected 0", ld_ovf); end
    checks++;
    if (i_mem_data !== NOP) begin errors++; $display("FAIL rst_nop: got %h expected %h", i_mem_data, NOP); end
    checks++;
    if (d_mem_data !== 64'h0) begin errors++; $display("FAIL rst_bus_release: got %h expected 0", d_mem_data); end
    tb_drv_en = 1'b0;
    release_and_time_clear();
  endtask

  task automatic test_pre_run_inert();
    // In LOAD: fetch returns NOP, stores are ignored, bus is not driven.
    @(negedge clk);
    i_mem_addr = 6'd0;
    d_mem_we   = 1'b1;
    d_mem_addr = 6'd7;
    tb_drv_en  = 1'b1;
    tb_drv     = '1;
    #1;
    checks++;
    if (i_mem_data !== NOP) begin errors++; $display("FAIL load_nop0: got %h expected %h", i_mem_data, NOP); end
    i_mem_addr = 6'd63;
    #1;
    checks++;
    if (i_mem_data !== NOP) begin errors++; $display("FAIL load_nop63: got %h expected %h", i_mem_data, NOP); end
    repeat (2) @(negedge clk);
    d_mem_we = 1'b0;
    tb_drv   = '0;
    #1;
    checks++;
    if (d_mem_data !== 64'h0) begin errors++; $display("FAIL load_bus_release: got %h expected 0", d_mem_data); end
    tb_drv_en = 1'b0;
  endtask

  task automatic test_load_program();
    logic [7:0] prog [7] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h05, 8'h20};
    for (int i = 0; i < 7; i++) send_byte(prog[i], (i == 6));
    stop_stream();
    #1;
    checks++;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL cpu_rst_early: got %0b expected 0", cpu_rst_n); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL run_ld_ready: got %0b expected 0", ld_ready); end
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL cpu_rst_release: got %0b expected 1", cpu_rst_n); end
    i_mem_addr = 6'd0;
    #1;
    checks++;
    if (i_mem_data !== 32'h0010_0093) begin errors++; $display("FAIL imem0: got %h expected 00100093", i_mem_data); end
    i_mem_addr = 6'd1;
    #1;
    checks++;
    if (i_mem_data !== 32'h0020_0513) begin errors++; $display("FAIL imem1: got %h expected 00200513", i_mem_data); end
    checks++;
    if (ld_ovf !== 1'b0) begin errors++; $display("FAIL prog_ovf: got %0b expected 0", ld_ovf); end
    for (int a = 0; a < 64; a++) begin
      d_mem_addr = 6'(a);
      #1;
      checks++;
      if (d_mem_data !== 64'h0) begin errors++; $display("FAIL dmem_clear[%0d]: got %h expected 0", a, d_mem_data); end
    end
  endtask

  task automatic test_run_write_read();
    @(negedge clk);
    d_mem_we = 1'b1; d_mem_addr = 6'd5; tb_drv_en = 1'b1; tb_drv = 64'hDEADBEEF_01234567;
    #1;
    checks++;
    if (d_mem_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL wr_bus_release: got %h expected deadbeef01234567", d_mem_data); end
    @(negedge clk);
    d_mem_we = 1'b0; tb_drv_en = 1'b0;
    #1;
    checks++;
    if (d_mem_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL rd_after_wr: got %h expected deadbeef01234567", d_mem_data); end
    // back-to-back stores to the two end addresses
    @(negedge clk);
    d_mem_we = 1'b1; d_mem_addr = 6'd63; tb_drv_en = 1'b1; tb_drv = 64'hA5A5_5A5A_F00D_CAFE;
    @(negedge clk);
    d_mem_addr = 6'd0; tb_drv = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    d_mem_we = 1'b0; tb_drv_en = 1'b0; d_mem_addr = 6'd63;
    #1;
    checks++;
    if (d_mem_data !== 64'hA5A5_5A5A_F00D_CAFE) begin errors++; $display("FAIL b2b_63: got %h expected a5a55a5af00dcafe", d_mem_data); end
    d_mem_addr = 6'd0;
    #1;
    checks++;
    if (d_mem_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL b2b_0: got %h expected 0123456789abcdef", d_mem_data); end
    d_mem_addr = 6'd6;
    #1;
    checks++;
    if (d_mem_data !== 64'h0) begin errors++; $display("FAIL neighbour_6: got %h expected 0", d_mem_data); end
  endtask

  task automatic test_run_ignores_loader();
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'hFF; ld_last = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL run_ready: got %0b expected 0", ld_ready); end
    ld_valid = 1'b0; ld_last = 1'b0;
    i_mem_addr = 6'd0;
    #1;
    checks++;
    if (i_mem_data !== 32'h0010_0093) begin errors++; $display("FAIL run_imem0_kept: got %h expected 00100093", i_mem_data); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    rst_n = 1'b0;
    d_mem_we = 1'b0; d_mem_addr = 6'd5; tb_drv_en = 1'b1; tb_drv = '0;
    #1;
    checks++;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL midrun_cpu_rst: got %0b expected 0", cpu_rst_n); end
    checks++;
    if (d_mem_data !== 64'h0) begin errors++; $display("FAIL midrun_bus_float: got %h expected 0", d_mem_data); end
    checks++;
    if (i_mem_data !== NOP) begin errors++; $display("FAIL midrun_nop: got %h expected %h", i_mem_data, NOP); end
    tb_drv_en = 1'b0;
    release_and_time_clear();
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] part [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) send_byte(part[i], 1'b0);
    stop_stream();
    rst_n = 1'b0;
    #1;
    checks++;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL midload_cpu_rst: got %0b expected 0", cpu_rst_n); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL midload_ready: got %0b expected 0", ld_ready); end
    release_and_time_clear();
    // single-byte program: ld_last on the very first byte
    send_byte(8'hAA, 1'b1);
    stop_stream();
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL onebyte_run: got %0b expected 1", cpu_rst_n); end
    i_mem_addr = 6'd0;
    #1;
    checks++;
    if (i_mem_data !== 32'h0000_00AA) begin errors++; $display("FAIL onebyte_imem0: got %h expected 000000aa", i_mem_data); end
    i_mem_addr = 6'd1;
    #1;
    checks++;
    if (i_mem_data !== 32'h0020_0513) begin errors++; $display("FAIL partial_lost_imem1: got %h expected 00200513", i_mem_data); end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    rst_n = 1'b0;
    release_and_time_clear();
    for (int k = 0; k < 256; k++) send_byte(8'(k), 1'b0);
    stop_stream();
    checks++;
    if (ld_ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %0b expected 0", ld_ovf); end
    for (int k = 0; k < 3; k++) send_byte(8'hFF, (k == 2));
    stop_stream();
    checks++;
    if (ld_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", ld_ovf); end
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL ovf_run: got %0b expected 1", cpu_rst_n); end
    i_mem_addr = 6'd0;
    #1;
    checks++;
    if (i_mem_data !== 32'h0302_0100) begin errors++; $display("FAIL ovf_imem0: got %h expected 03020100", i_mem_data); end
    i_mem_addr = 6'd1;
    #1;
    checks++;
    if (i_mem_data !== 32'h0706_0504) begin errors++; $display("FAIL ovf_imem1: got %h expected 07060504", i_mem_data); end
    i_mem_addr = 6'd63;
    #1;
    checks++;
    if (i_mem_data !== 32'hFFFE_FDFC) begin errors++; $display("FAIL ovf_imem63: got %h expected fffefdfc", i_mem_data); end
    d_mem_addr = 6'd5;
    #1;
    checks++;
    if (d_mem_data !== 64'h0) begin errors++; $display("FAIL reclear_dmem5: got %h expected 0", d_mem_data); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_pre_run_inert();
    test_load_program();
    test_run_write_read();
    test_run_ignores_loader();
    test_reset_mid_run();
    test_reset_mid_load();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
